// File: rtl/vga_timing_gen_param.sv
// Parametrised VGA timing generator: programmable porches, sync widths, pixel divider and polarity.
// Optional colour-bar test pattern is enabled by defining VGA_TEST_PATTERN_EN.
module vga_timing_gen_param #(
    parameter int       COLOR_W = 10,
    parameter int       PIX_DIV = 2,
    parameter int       H_SYNC  = 96,
    parameter int       H_BP    = 48,
    parameter int       H_ACT   = 640,
    parameter int       H_FP    = 16,
    parameter int       V_SYNC  = 2,
    parameter int       V_BP    = 33,
    parameter int       V_ACT   = 480,
    parameter int       V_FP    = 10,
    parameter logic     HS_POL  = 1'b0,
    parameter logic     VS_POL  = 1'b0
) (
    input  logic               Clock,
    input  logic               Reset,
    input  logic [COLOR_W-1:0] iRed,
    input  logic [COLOR_W-1:0] iGreen,
    input  logic [COLOR_W-1:0] iBlue,
`ifdef VGA_TEST_PATTERN_EN
    input  logic               iPattern,
`endif
    output logic [10:0]        oCoord_X,
    output logic [10:0]        oCoord_Y,
    output logic               oPix_req,
    output logic               oLine_start,
    output logic               oFrame_start,
    output logic [COLOR_W-1:0] oVGA_R,
    output logic [COLOR_W-1:0] oVGA_G,
    output logic [COLOR_W-1:0] oVGA_B,
    output logic               oVGA_H_SYNC,
    output logic               oVGA_V_SYNC,
    output logic               oVGA_BLANK,
    output logic               oVGA_SYNC,
    output logic               oVGA_CLOCK
);

    localparam int H_TOT = H_SYNC + H_BP + H_ACT + H_FP;
    localparam int V_TOT = V_SYNC + V_BP + V_ACT + V_FP;
    localparam int DIV_W = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(PIX_DIV - 1);
    localparam logic [10:0] H_LAST  = 11'(H_TOT - 1);
    localparam logic [10:0] V_LAST  = 11'(V_TOT - 1);
    localparam logic [10:0] H_SYNC_E = 11'(H_SYNC);
    localparam logic [10:0] V_SYNC_E = 11'(V_SYNC);
    localparam logic [10:0] H_ACT_S = 11'(H_SYNC + H_BP);
    localparam logic [10:0] H_ACT_E = 11'(H_SYNC + H_BP + H_ACT);
    localparam logic [10:0] V_ACT_S = 11'(V_SYNC + V_BP);
    localparam logic [10:0] V_ACT_E = 11'(V_SYNC + V_BP + V_ACT);

    logic [DIV_W-1:0]   div_q, div_d;
    logic [10:0]        h_q, h_d;
    logic [10:0]        v_q, v_d;
    logic               hs_q, vs_q, blank_q, ls_q, fs_q;
    logic [COLOR_W-1:0] r_q, g_q, b_q;

    logic               tick, h_end, v_end, active;
    logic [COLOR_W-1:0] src_r, src_g, src_b;

    always_comb begin
        tick   = (div_q == DIV_LAST);
        h_end  = (h_q == H_LAST);
        v_end  = (v_q == V_LAST);
        active = (h_q >= H_ACT_S) && (h_q < H_ACT_E) && (v_q >= V_ACT_S) && (v_q < V_ACT_E);

        div_d = tick ? '0 : div_q + 1'b1;
        h_d   = h_q;
        v_d   = v_q;
        if (tick) begin
            h_d = h_end ? 11'd0 : h_q + 11'd1;
            if (h_end) begin
                v_d = v_end ? 11'd0 : v_q + 11'd1;
            end
        end
    end

    assign oCoord_X = h_q - H_ACT_S;
    assign oCoord_Y = v_q - V_ACT_S;
    assign oPix_req = tick & active;

`ifdef VGA_TEST_PATTERN_EN
    // Bar index is the active X scaled into eight equal bands; each bit lights one channel.
    logic [2:0] bar;
    assign bar   = 3'(({oCoord_X, 3'b000}) / 14'(H_ACT));
    assign src_r = iPattern ? {COLOR_W{bar[2]}} : iRed;
    assign src_g = iPattern ? {COLOR_W{bar[1]}} : iGreen;
    assign src_b = iPattern ? {COLOR_W{bar[0]}} : iBlue;
`else
    assign src_r = iRed;
    assign src_g = iGreen;
    assign src_b = iBlue;
`endif

    always_ff @(posedge Clock) begin
        if (Reset) begin
            div_q   <= '0;
            h_q     <= 11'd0;
            v_q     <= 11'd0;
            hs_q    <= ~HS_POL;
            vs_q    <= ~VS_POL;
            blank_q <= 1'b0;
            r_q     <= '0;
            g_q     <= '0;
            b_q     <= '0;
            ls_q    <= 1'b0;
            fs_q    <= 1'b0;
        end else begin
            div_q <= div_d;
            h_q   <= h_d;
            v_q   <= v_d;
            // Pulses land in the cycle the counters wrap to column 0.
            ls_q  <= tick & h_end;
            fs_q  <= tick & h_end & v_end;
            if (tick) begin
                hs_q    <= (h_q < H_SYNC_E) ? HS_POL : ~HS_POL;
                vs_q    <= (v_q < V_SYNC_E) ? VS_POL : ~VS_POL;
                blank_q <= active;
                r_q     <= active ? src_r : '0;
                g_q     <= active ? src_g : '0;
                b_q     <= active ? src_b : '0;
            end
        end
    end

    assign oVGA_R       = r_q;
    assign oVGA_G       = g_q;
    assign oVGA_B       = b_q;
    assign oVGA_H_SYNC  = hs_q;
    assign oVGA_V_SYNC  = vs_q;
    assign oVGA_BLANK   = blank_q;
    assign oLine_start  = ls_q;
    assign oFrame_start = fs_q;
    assign oVGA_SYNC    = 1'b0;
    assign oVGA_CLOCK   = Clock;

endmodule

// File: tb/tb_vga_timing_gen_param.sv
// Bench for vga_timing_gen_param: small 8x6 timing, PIX_DIV=2 and PIX_DIV=1 instances side by side.
// Define VGA_TEST_PATTERN_EN to also exercise the colour-bar pattern.
module tb_vga_timing_gen_param;
  localparam int W = 33;
  localparam logic [W-1:0] RESET_WORD = {1'b0, 1'b1, 1'b1, 30'd0};

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic pat = 1'b0;
  int n_tests = 0;
  int n_fail = 0;
  logic [W-1:0] exp_q[$];

  always #5 clk = ~clk;

  logic [10:0] x0, y0, x1, y1;
  logic req0, req1, ls0, ls1, fs0, fs1, hs0, hs1, vs0, vs1, bl0, bl1, sy0, sy1, ck0, ck1;
  logic [9:0] r0, g0, b0, r1, g1, b1;
  logic [9:0] c0, c1, ir0, ig0, ib0, ir1, ig1, ib1;

  // Client returns RGB combinationally from the requested coordinate.
  assign c0  = {x0[5:0], 4'b0000} + {4'b0000, y0[5:0]};
  assign c1  = {x1[5:0], 4'b0000} + {4'b0000, y1[5:0]};
  assign ir0 = c0 + 10'd1;
  assign ig0 = c0 + 10'd100;
  assign ib0 = 10'h3FF - c0;
  assign ir1 = c1 + 10'd1;
  assign ig1 = c1 + 10'd100;
  assign ib1 = 10'h3FF - c1;

  wire [W-1:0] obs0 = {bl0, hs0, vs0, r0, g0, b0};
  wire [W-1:0] obs1 = {bl1, hs1, vs1, r1, g1, b1};

  vga_timing_gen_param #(
    .COLOR_W(10), .PIX_DIV(2), .H_SYNC(2), .H_BP(1), .H_ACT(4), .H_FP(1),
    .V_SYNC(1), .V_BP(1), .V_ACT(3), .V_FP(1), .HS_POL(1'b0), .VS_POL(1'b0)
  ) dut (
    .Clock(clk), .Reset(rst), .iRed(ir0), .iGreen(ig0), .iBlue(ib0),
`ifdef VGA_TEST_PATTERN_EN
    .iPattern(pat),
`endif
    .oCoord_X(x0), .oCoord_Y(y0), .oPix_req(req0), .oLine_start(ls0), .oFrame_start(fs0),
    .oVGA_R(r0), .oVGA_G(g0), .oVGA_B(b0), .oVGA_H_SYNC(hs0), .oVGA_V_SYNC(vs0),
    .oVGA_BLANK(bl0), .oVGA_SYNC(sy0), .oVGA_CLOCK(ck0)
  );

  vga_timing_gen_param #(
    .COLOR_W(10), .PIX_DIV(1), .H_SYNC(2), .H_BP(1), .H_ACT(4), .H_FP(1),
    .V_SYNC(1), .V_BP(1), .V_ACT(3), .V_FP(1), .HS_POL(1'b0), .VS_POL(1'b0)
  ) dut1 (
    .Clock(clk), .Reset(rst), .iRed(ir1), .iGreen(ig1), .iBlue(ib1),
`ifdef VGA_TEST_PATTERN_EN
    .iPattern(pat),
`endif
    .oCoord_X(x1), .oCoord_Y(y1), .oPix_req(req1), .oLine_start(ls1), .oFrame_start(fs1),
    .oVGA_R(r1), .oVGA_G(g1), .oVGA_B(b1), .oVGA_H_SYNC(hs1), .oVGA_V_SYNC(vs1),
    .oVGA_BLANK(bl1), .oVGA_SYNC(sy1), .oVGA_CLOCK(ck1)
  );

  function automatic logic is_act(input int n);
    int h, v;
    h = n % 8;
    v = (n / 8) % 6;
    return (h >= 3) && (h < 7) && (v >= 2) && (v < 5);
  endfunction

  // Expected registered outputs after the tick that processes counter index n.
  function automatic logic [W-1:0] exp_word(input int n);
    int h, v, x, y, bar;
    logic a;
    logic [9:0] code, r, g, b;
    h = n % 8;
    v = (n / 8) % 6;
    x = h - 3;
    y = v - 2;
    a = is_act(n);
    code = 10'(x * 16 + y);
    r = 10'd0;
    g = 10'd0;
    b = 10'd0;
    if (a && pat) begin
      bar = x * 8 / 4;
      r = bar[2] ? 10'h3FF : 10'd0;
      g = bar[1] ? 10'h3FF : 10'd0;
      b = bar[0] ? 10'h3FF : 10'd0;
    end else if (a) begin
      r = code + 10'd1;
      g = code + 10'd100;
      b = 10'h3FF - code;
    end
    return {a, (h >= 2), (v >= 1), r, g, b};
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Runs edges 1..n_edges after a reset release, scoreboarding every cycle.
  task automatic run_check(input int sel, input int p, input int n_edges);
    logic [W-1:0] held, got;
    logic tick, exp_req, exp_ls, exp_fs, o_req, o_ls, o_fs;
    logic [10:0] o_x, o_y;
    int n, last_fs, req_cnt;
    held = RESET_WORD;
    last_fs = 0;
    req_cnt = 0;
    exp_q.delete();
    for (int e = 1; e <= n_edges; e++) begin
      tick = ((e % p) == 0);
      n = (e - 1) / p;
      exp_req = tick && is_act(n);
      o_req = sel ? req1 : req0;
      o_x = sel ? x1 : x0;
      o_y = sel ? y1 : y0;
      n_tests++;
      if (o_req !== exp_req) begin
        n_fail++;
        $display("FAIL pix_req dut%0d e=%0d got=%b exp=%b", sel, e, o_req, exp_req);
      end
      if (exp_req) begin
        req_cnt++;
        n_tests++;
        if (o_x !== 11'(n % 8 - 3) || o_y !== 11'((n / 8) % 6 - 2)) begin
          n_fail++;
          $display("FAIL coord dut%0d e=%0d got=(%0d,%0d) exp=(%0d,%0d)", sel, e, o_x, o_y,
                   n % 8 - 3, (n / 8) % 6 - 2);
        end
      end
      if (tick) exp_q.push_back(exp_word(n));
      exp_ls = tick && (n % 8 == 7);
      exp_fs = tick && (n % 48 == 47);
      @(posedge clk);
      @(negedge clk);
      if (tick) held = exp_q.pop_front();
      got = sel ? obs1 : obs0;
      o_ls = sel ? ls1 : ls0;
      o_fs = sel ? fs1 : fs0;
      n_tests++;
      if (got !== held) begin
        n_fail++;
        $display("FAIL outputs dut%0d e=%0d got=%h exp=%h", sel, e, got, held);
      end
      n_tests++;
      if (o_ls !== exp_ls || o_fs !== exp_fs) begin
        n_fail++;
        $display("FAIL pulses dut%0d e=%0d got ls=%b fs=%b exp ls=%b fs=%b", sel, e, o_ls, o_fs,
                 exp_ls, exp_fs);
      end
      if (o_fs === 1'b1) begin
        if (last_fs != 0) begin
          n_tests++;
          if (e - last_fs != 48 * p) begin
            n_fail++;
            $display("FAIL frame_period dut%0d got=%0d exp=%0d", sel, e - last_fs, 48 * p);
          end
        end
        last_fs = e;
      end
      if (e == 48 * p) begin
        n_tests++;
        if (req_cnt != 12) begin
          n_fail++;
          $display("FAIL req_count dut%0d got=%0d exp=12", sel, req_cnt);
        end
      end
    end
  endtask

  task automatic check_reset_state(input string tag);
    n_tests++;
    if (obs0 !== RESET_WORD || obs1 !== RESET_WORD) begin
      n_fail++;
      $display("FAIL %s_outputs got=%h/%h exp=%h", tag, obs0, obs1, RESET_WORD);
    end
    n_tests++;
    if ({ls0, fs0, ls1, fs1, req0, req1} !== 6'b0) begin
      n_fail++;
      $display("FAIL %s_pulses got=%b exp=000000", tag, {ls0, fs0, ls1, fs1, req0, req1});
    end
    n_tests++;
    if (x0 !== 11'd2045 || y0 !== 11'd2046 || x1 !== 11'd2045 || y1 !== 11'd2046) begin
      n_fail++;
      $display("FAIL %s_counters got=(%0d,%0d)/(%0d,%0d) exp=(2045,2046)", tag, x0, y0, x1, y1);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_reset_state("reset");
    n_tests++;
    if (sy0 !== 1'b0 || sy1 !== 1'b0 || ck0 !== clk || ck1 !== clk) begin
      n_fail++;
      $display("FAIL sync_clock got sync=%b%b clk=%b%b exp sync=00 clk=%b", sy0, sy1, ck0, ck1, clk);
    end
    rst = 1'b0;
  endtask

  task automatic test_frames();
    do_reset();
    run_check(0, 2, 200);
  endtask

  task automatic test_pix_div1();
    do_reset();
    run_check(1, 1, 100);
  endtask

  task automatic test_mid_reset();
    do_reset();
    run_check(0, 2, 59);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_reset_state("mid_reset");
    rst = 1'b0;
    run_check(0, 2, 200);
  endtask

  task automatic test_reset_on_tick();
    do_reset();
    run_check(0, 2, 15);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_reset_state("tick_reset");
    rst = 1'b0;
    run_check(0, 2, 40);
  endtask

`ifdef VGA_TEST_PATTERN_EN
  task automatic test_pattern();
    pat = 1'b1;
    do_reset();
    run_check(0, 2, 100);
    do_reset();
    run_check(1, 1, 50);
    pat = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_frames();
    test_pix_div1();
    test_mid_reset();
    test_reset_on_tick();
`ifdef VGA_TEST_PATTERN_EN
    test_pattern();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
